// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execution unit: operation codes and controller states.
package alu_exec_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic is_mul_op(input logic [ALU_CTRL_WIDTH-1:0] code);
    return (code == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// 2-read/1-write register file: x0 hard-wired to zero, a0 exported as a tap.
module alu_exec_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int A0_INDEX   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // next-state of the file: a single write port that never touches x0
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d[0] = '0;
    end
  end

  // storage flops with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
  assign a0     = regs_q[A0_INDEX];

endmodule

// File: rtl/alu_exec_unit.sv
// Execution unit: register file, operand-2 mux, single-cycle ALU and an
// iterative shift-add multiplier behind a valid/ready issue handshake.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int A0_INDEX   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [ADDR_WIDTH-1:0]     rs1,
  input  logic [ADDR_WIDTH-1:0]     rs2,
  input  logic [ADDR_WIDTH-1:0]     rd,
  input  logic                      wb_en,
  input  logic                      alu_src,
  input  logic [DATA_WIDTH-1:0]     imm_op,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      result_valid,
  output logic                      eq,
  output logic [DATA_WIDTH-1:0]     a0
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  op_eq_q, op_eq_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wb_en_q, wb_en_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  eq_q, eq_d;
  logic                  result_valid_q, result_valid_d;

  logic [DATA_WIDTH-1:0] rdata1_s, rdata2_s;
  logic [DATA_WIDTH-1:0] op1_s, op2_s;
  logic [SHAMT_W-1:0]    shamt_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic [DATA_WIDTH-1:0] acc_step_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  is_mul_s;
  logic                  mul_last_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  alu_exec_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .A0_INDEX   (A0_INDEX)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s),
    .a0     (a0)
  );

  assign op1_s      = rdata1_s;
  assign op2_s      = alu_src ? imm_op : rdata2_s;
  assign shamt_s    = op2_s[SHAMT_W-1:0];
  assign accept_s   = issue_valid && ready_s;
  assign is_mul_s   = is_mul_op(alu_ctrl);
  assign mul_last_s = (count_q == CNT_LAST);
  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // single-cycle ALU; unknown codes produce zero
  always_comb begin
    alu_res_s = '0;
    case (alu_ctrl)
      OP_ADD:  alu_res_s = op1_s + op2_s;
      OP_SUB:  alu_res_s = op1_s - op2_s;
      OP_AND:  alu_res_s = op1_s & op2_s;
      OP_OR:   alu_res_s = op1_s | op2_s;
      OP_XOR:  alu_res_s = op1_s ^ op2_s;
      OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1_s) < $signed(op2_s))};
      OP_SLL:  alu_res_s = op1_s << shamt_s;
      OP_SRL:  alu_res_s = op1_s >> shamt_s;
      default: alu_res_s = '0;
    endcase
  end

  // controller next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // controller outputs
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE: ready_s = 1'b1;
      ST_MUL:  ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  // datapath next values and writeback port selection
  always_comb begin
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    count_d        = count_q;
    op_eq_d        = op_eq_q;
    rd_d           = rd_q;
    wb_en_d        = wb_en_q;
    result_d       = result_q;
    eq_d           = eq_q;
    result_valid_d = 1'b0;
    we_s           = 1'b0;
    waddr_s        = rd;
    wdata_s        = alu_res_s;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          mcand_d  = op1_s;
          mplier_d = op2_s;
          acc_d    = '0;
          count_d  = '0;
          op_eq_d  = (op1_s == op2_s);
          rd_d     = rd;
          wb_en_d  = wb_en;
        end else if (accept_s) begin
          result_d       = alu_res_s;
          eq_d           = (op1_s == op2_s);
          result_valid_d = 1'b1;
          we_s           = wb_en;
        end else begin
          result_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = acc_step_s;
        count_d  = count_q + CNT_W'(1);
        if (mul_last_s) begin
          result_d       = acc_step_s;
          eq_d           = op_eq_q;
          result_valid_d = 1'b1;
          we_s           = wb_en_q;
          waddr_s        = rd_q;
          wdata_s        = acc_step_s;
        end else begin
          result_valid_d = 1'b0;
        end
      end
      default: begin
        result_valid_d = 1'b0;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      count_q        <= '0;
      op_eq_q        <= 1'b0;
      rd_q           <= '0;
      wb_en_q        <= 1'b0;
      result_q       <= '0;
      eq_q           <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      op_eq_q        <= op_eq_d;
      rd_q           <= rd_d;
      wb_en_q        <= wb_en_d;
      result_q       <= result_d;
      eq_q           <= eq_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign issue_ready  = ready_s;
  assign result       = result_q;
  assign eq           = eq_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the single-cycle regfile/mux/ALU datapath. It holds a register file with two read ports and one write port, an operand-2 mux (register or immediate) and an extended ALU. It adds an iterative shift-add multiplier behind a valid/ready issue handshake, and writes results back to rd internally. It sits between decode/control and the top level, which observes a0.

Parameters:
ADDR_WIDTH, 5, register address width; the file has 2**ADDR_WIDTH registers.
DATA_WIDTH, 32, register, operand and result width.
A0_INDEX, 10, register index driven onto a0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
issue_valid  in  1  an operation is presented this cycle.
issue_ready  out  1  the unit can accept an operation this cycle.
rs1  in  ADDR_WIDTH  source register 1.
rs2  in  ADDR_WIDTH  source register 2.
rd  in  ADDR_WIDTH  destination register.
wb_en  in  1  write the result to rd; when 0, compute only.
alu_src  in  1  selects operand 2: 0 = reg[rs2], 1 = imm_op.
imm_op  in  DATA_WIDTH  immediate operand.
alu_ctrl  in  4  operation code (see package).
result  out  DATA_WIDTH  registered result of the last completed operation.
result_valid  out  1  one-cycle pulse when result updates.
eq  out  1  registered (op1 == op2) of the last completed operation.
a0  out  DATA_WIDTH  combinational read of reg[A0_INDEX].

Behaviour:
- Reset (rst=1 at an edge): all registers cleared to 0; result=0, eq=0, result_valid=0; FSM to IDLE; issue_ready=1 from the following cycle.
- Register file: asynchronous read, synchronous write. reg[0] reads 0 and ignores writes. A write at an edge is visible to reads in the next cycle.
- Handshake: an op is accepted at an edge where issue_valid && issue_ready. Operands are sampled from the combinational reads in the accept cycle.
- Ops: ADD, SUB, AND, OR, XOR, SLT (signed, result 0/1), SLL, SRL, MUL.
  - Shifts use op2[$clog2(DATA_WIDTH)-1:0].
  - ADD, SUB and MUL wrap modulo 2**DATA_WIDTH.
  - An undefined code yields result 0, eq still computed, writeback still performed.
- Single-cycle ops (FSM stays IDLE):
  - At the accept edge E: result, eq and reg[rd] (if wb_en) update.
  - result_valid=1 in the cycle after E.
  - issue_ready stays 1, so back-to-back issue is allowed.
- MUL (FSM IDLE -> MUL -> IDLE):
  - At accept edge E: multiplicand=op1, multiplier=op2, acc=0, count=0; go to MUL.
  - In MUL, issue_ready=0. At each edge: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++.
  - At edge E+DATA_WIDTH (count reaches DATA_WIDTH):
    - result=acc-final and eq=(op1==op2) as sampled at accept.
    - reg[rd] is written if wb_en was 1 at accept; rd and wb_en are latched at accept.
    - FSM returns to IDLE.
  - result_valid=1 and issue_ready=1 in the cycle after E+DATA_WIDTH.
- issue_valid while busy: ignored; the issuer must hold its op.
- Reset during MUL: the op is aborted with no writeback and no result_valid; reset clears everything as above.
- Writes to rd=0: no effect; result and result_valid still produced.
- a0 follows reg[A0_INDEX] combinationally, including a same-cycle view of writes from the previous edge.

Decomposition:
- Package alu_exec_pkg holds:
  - the alu_ctrl enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, MUL=8;
  - the FSM state enum: IDLE, MUL.
- One sub-module, alu_exec_regfile: parametrised 2R1W file with the x0 rule and the a0 tap.
- Operand mux, ALU and multiplier FSM live in alu_exec_unit.

Test Plan:
- Reset, then ADD with imm: rd=10, rs1=0, alu_src=1, imm=5 -> result_valid pulse with result=5; a0=5 the next cycle; eq=0.
- Back-to-back: reg1=7, reg2=7 loaded, then SUB rd=3, rs1=1, rs2=2 issued consecutively -> results 7, 7, 0 in consecutive cycles; eq=1 on the SUB; reg3=0.
- MUL 7*6 with DATA_WIDTH=32 -> issue_ready=0 for 32 cycles; result_valid after accept+32 edges with result=42; a second op held during MUL is accepted only when ready returns.
- MUL 0xFFFFFFFF*2 -> result 0xFFFFFFFE (wrap). SLT -1 vs 1 -> 1. SRL 0x80000000 by imm 35 -> shift 3 -> 0x10000000.
- Write to rd=0 with value 9 -> reads of reg0 return 0; result=9 with result_valid=1.
- rst asserted at cycle 10 of a MUL -> no result_valid, rd unchanged (0), issue_ready=1 after reset, all registers read 0.
